// File: rtl/pong_referee.sv
// pong_referee: per-frame referee for a two-player pong game.
// Samples the ball and paddle positions on each frame_tick and decides wall
// bounces, paddle hits and misses. Sends 1-cycle flip/recentre commands back
// to the ball mover and keeps the scores and serve/play/game-over sequencing.
module pong_referee #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 624,
  parameter int SCORE_MAX    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] ballx,
  input  logic [9:0] bally,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       flip_x,
  output logic       flip_y,
  output logic       ball_reset,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serving,
  output logic       game_over
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]       SMAX     = 4'(SCORE_MAX);
  // Positions at or above this are a ball that ran past 0 and wrapped.
  localparam logic [9:0]       UNDERFLOW = 10'd960;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    SCORED,
    OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;
  logic             hold_l;
  logic             hold_r;
  logic             point_l;   // 1: left player takes the point in SCORED

  // All geometry is 11 bits wide so position + size can never wrap.
  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] pl_top;
  logic [10:0] pr_top;
  logic        at_left;
  logic        at_right;
  logic        ov_l;
  logic        ov_r;
  logic        wall_y;
  logic        hit_l;
  logic        hit_r;
  logic        miss_l;
  logic        miss_r;
  logic [3:0]  score_l_inc;
  logic [3:0]  score_r_inc;

  assign bx     = (ballx >= UNDERFLOW) ? 11'd0 : {1'b0, ballx};
  assign by     = (bally >= UNDERFLOW) ? 11'd0 : {1'b0, bally};
  assign pl_top = {1'b0, paddle_l_y};
  assign pr_top = {1'b0, paddle_r_y};

  assign at_left  = bx <= 11'(PADDLE_X_L);
  assign at_right = (bx + 11'(BALL_SIZE)) >= 11'(PADDLE_X_R);

  assign ov_l = ((by + 11'(BALL_SIZE)) > pl_top) && (by < (pl_top + 11'(PADDLE_H)));
  assign ov_r = ((by + 11'(BALL_SIZE)) > pr_top) && (by < (pr_top + 11'(PADDLE_H)));

  assign wall_y = (by == 11'd0) || (by >= 11'(V_RES - BALL_SIZE));

  // A hold blocks a second flip while the ball is still inside the paddle zone.
  assign hit_l  = at_left  && !hold_l &&  ov_l;
  assign miss_l = at_left  && !hold_l && !ov_l;
  assign hit_r  = at_right && !hold_r &&  ov_r;
  assign miss_r = at_right && !hold_r && !ov_r;

  // Scores saturate at SCORE_MAX.
  assign score_l_inc = (score_l == SMAX) ? score_l : score_l + 4'd1;
  assign score_r_inc = (score_r == SMAX) ? score_r : score_r + 4'd1;

  // Referee FSM: sequencing, holds, scores and registered command pulses.
  // NOTE: every register here, including the pulse outputs, takes the async
  // reset so a pulse in flight is killed immediately when rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SERVE;
      serve_cnt  <= '0;
      hold_l     <= 1'b0;
      hold_r     <= 1'b0;
      point_l    <= 1'b0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      flip_x     <= 1'b0;
      flip_y     <= 1'b0;
      ball_reset <= 1'b0;
      serving    <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make the commands 1-cycle pulses; any
      // branch below that fires overrides them for this cycle only.
      flip_x     <= 1'b0;
      flip_y     <= 1'b0;
      ball_reset <= 1'b0;

      case (state)
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == CNT_LAST) begin
              serve_cnt <= '0;
              state     <= PLAY;
              serving   <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
        end

        PLAY: begin
          if (frame_tick) begin
            if (!at_left)   hold_l <= 1'b0;
            else if (hit_l) hold_l <= 1'b1;
            if (!at_right)  hold_r <= 1'b0;
            else if (hit_r) hold_r <= 1'b1;

            // A miss takes priority and suppresses any wall bounce.
            if (miss_l) begin
              state      <= SCORED;
              point_l    <= 1'b0;
              ball_reset <= 1'b1;
            end else if (miss_r) begin
              state      <= SCORED;
              point_l    <= 1'b1;
              ball_reset <= 1'b1;
            end else begin
              flip_x <= hit_l || hit_r;
              flip_y <= wall_y;
            end
          end
        end

        SCORED: begin
          if (point_l) score_l <= score_l_inc;
          else         score_r <= score_r_inc;

          if ((point_l ? score_l_inc : score_r_inc) == SMAX) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state   <= SERVE;
            serving <= 1'b1;
            hold_l  <= 1'b0;
            hold_r  <= 1'b0;
          end
        end

        OVER: begin
          // Frozen until rst.
        end

        default: begin
          state   <= SERVE;
          serving <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_referee.sv
// tb_pong_referee: scenario tasks driving pong_referee one clock at a time.
// Each step pushes its expected outputs to a scoreboard queue when the
// stimulus is driven and pops/compares them once the DUT has clocked.
module tb_pong_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] ballx;
  logic [9:0] bally;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic       flip_x;
  logic       flip_y;
  logic       ball_reset;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       serving;
  logic       game_over;

  typedef struct packed {
    logic       fx;
    logic       fy;
    logic       br;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       sv;
    logic       go;
  } out_t;

  out_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_sl = 4'd0;
  logic [3:0] exp_sr = 4'd0;

  pong_referee dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .ballx      (ballx),
    .bally      (bally),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .flip_x     (flip_x),
    .flip_y     (flip_y),
    .ball_reset (ball_reset),
    .score_l    (score_l),
    .score_r    (score_r),
    .serving    (serving),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic out_t outs();
    return '{flip_x, flip_y, ball_reset, score_l, score_r, serving, game_over};
  endfunction

  function automatic out_t exp_o(logic fx, logic fy, logic br, logic sv, logic go);
    return '{fx, fy, br, exp_sl, exp_sr, sv, go};
  endfunction

  // Drive one cycle (optionally a frame_tick) and score the registered result.
  task automatic step(input string name, input logic tick,
                      input logic [9:0] bx, input logic [9:0] by,
                      input logic [9:0] pl, input logic [9:0] pr,
                      input out_t e);
    out_t got;
    out_t want;
    @(negedge clk);
    frame_tick = tick;
    ballx      = bx;
    bally      = by;
    paddle_l_y = pl;
    paddle_r_y = pr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    got  = outs();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got fx=%b fy=%b br=%b sl=%0d sr=%0d sv=%b go=%b, expected fx=%b fy=%b br=%b sl=%0d sr=%0d sv=%b go=%b",
               name, got.fx, got.fy, got.br, got.sl, got.sr, got.sv, got.go,
               want.fx, want.fy, want.br, want.sl, want.sr, want.sv, want.go);
    end
  endtask

  // Asynchronous reset check: outputs must drop to reset values without a clock edge.
  task automatic async_reset_check(input string name);
    out_t got;
    out_t want;
    rst = 1'b1;
    exp_sl = 4'd0;
    exp_sr = 4'd0;
    exp_q.push_back(exp_o(0, 0, 0, 1, 0));
    #1;
    got  = outs();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got fx=%b fy=%b br=%b sl=%0d sr=%0d sv=%b go=%b, expected reset values",
               name, got.fx, got.fy, got.br, got.sl, got.sr, got.sv, got.go);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full serve: serving stays high through 59 ticks and drops after the 60th.
  task automatic serve_phase(input string name);
    for (int i = 0; i < 60; i++)
      step(name, 1'b1, 10'd320, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, i < 59, 0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    async_reset_check("reset_state");
  endtask

  task automatic test_serve();
    // Idle cycle without a tick must not advance the serve counter.
    step("serve_idle", 1'b0, 10'd320, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, 1, 0));
    serve_phase("serve");
  endtask

  task automatic test_walls();
    step("wall_top",        1'b1, 10'd320, 10'd0,    10'd200, 10'd200, exp_o(0, 1, 0, 0, 0));
    step("wall_pulse_end",  1'b0, 10'd320, 10'd0,    10'd200, 10'd200, exp_o(0, 0, 0, 0, 0));
    step("wall_bottom",     1'b1, 10'd320, 10'd472,  10'd200, 10'd200, exp_o(0, 1, 0, 0, 0));
    step("wall_below_edge", 1'b1, 10'd320, 10'd471,  10'd200, 10'd200, exp_o(0, 0, 0, 0, 0));
    step("wall_underflow",  1'b1, 10'd320, 10'd1000, 10'd200, 10'd200, exp_o(0, 1, 0, 0, 0));
    step("wall_clear_y1",   1'b1, 10'd320, 10'd1,    10'd200, 10'd200, exp_o(0, 0, 0, 0, 0));
  endtask

  task automatic test_left_hit();
    step("left_hit",        1'b1, 10'd16,   10'd100, 10'd80, 10'd200, exp_o(1, 0, 0, 0, 0));
    step("left_hold",       1'b1, 10'd16,   10'd100, 10'd80, 10'd200, exp_o(0, 0, 0, 0, 0));
    step("left_leave",      1'b1, 10'd20,   10'd100, 10'd80, 10'd200, exp_o(0, 0, 0, 0, 0));
    step("left_rehit",      1'b1, 10'd16,   10'd100, 10'd80, 10'd200, exp_o(1, 0, 0, 0, 0));
    step("left_away",       1'b1, 10'd300,  10'd100, 10'd80, 10'd200, exp_o(0, 0, 0, 0, 0));
    // Underflowed x counts as the left plane; y=143 is the last overlapping row.
    step("left_edge_uflow", 1'b1, 10'd1000, 10'd143, 10'd80, 10'd200, exp_o(1, 0, 0, 0, 0));
    step("left_away2",      1'b1, 10'd300,  10'd240, 10'd80, 10'd200, exp_o(0, 0, 0, 0, 0));
  endtask

  task automatic test_miss();
    step("miss_pulse", 1'b1, 10'd16, 10'd300, 10'd80, 10'd200, exp_o(0, 0, 1, 0, 0));
    exp_sr = 4'd1;
    // A wall tick during SCORED must be ignored.
    step("miss_score", 1'b1, 10'd320, 10'd0, 10'd80, 10'd200, exp_o(0, 0, 0, 1, 0));
    serve_phase("serve_after_miss");
    // Miss at the top wall: scoring suppresses flip_y.
    step("miss_top_pulse", 1'b1, 10'd16, 10'd0, 10'd80, 10'd200, exp_o(0, 0, 1, 0, 0));
    exp_sr = 4'd2;
    step("miss_top_score", 1'b0, 10'd320, 10'd240, 10'd80, 10'd200, exp_o(0, 0, 0, 1, 0));
    serve_phase("serve_after_miss2");
  endtask

  task automatic test_corner();
    step("right_not_plane", 1'b1, 10'd615, 10'd0,   10'd200, 10'd0, exp_o(0, 1, 0, 0, 0));
    step("corner",          1'b1, 10'd616, 10'd0,   10'd200, 10'd0, exp_o(1, 1, 0, 0, 0));
    step("corner_hold",     1'b1, 10'd616, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, 0, 0));
    step("corner_away",     1'b1, 10'd300, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, 0, 0));
  endtask

  task automatic test_end_and_reset();
    for (int k = 1; k <= 9; k++) begin
      step("rmiss_pulse", 1'b1, 10'd620, 10'd300, 10'd200, 10'd0, exp_o(0, 0, 1, 0, 0));
      exp_sl = 4'(k);
      step("rmiss_score", 1'b0, 10'd320, 10'd240, 10'd200, 10'd0, exp_o(0, 0, 0, k < 9, k == 9));
      if (k < 9) serve_phase("serve_game");
    end
    step("over_ignore_wall", 1'b1, 10'd320, 10'd0,   10'd200, 10'd200, exp_o(0, 0, 0, 0, 1));
    step("over_ignore_miss", 1'b1, 10'd16,  10'd300, 10'd80,  10'd200, exp_o(0, 0, 0, 0, 1));
    step("over_hold",        1'b0, 10'd320, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, 0, 1));
    async_reset_check("reset_from_over");
    // Reset with a flip_y pulse in flight.
    serve_phase("serve_post_reset");
    step("flight_wall", 1'b1, 10'd320, 10'd0, 10'd200, 10'd200, exp_o(0, 1, 0, 0, 0));
    async_reset_check("reset_pulse_in_flight");
    // Reset mid-SERVE must restart the serve count.
    for (int i = 0; i < 10; i++)
      step("serve_partial", 1'b1, 10'd320, 10'd240, 10'd200, 10'd200, exp_o(0, 0, 0, 1, 0));
    async_reset_check("reset_mid_serve");
    serve_phase("serve_restarted");
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    ballx      = 10'd320;
    bally      = 10'd240;
    paddle_l_y = 10'd200;
    paddle_r_y = 10'd200;
    test_reset();
    test_serve();
    test_walls();
    test_left_hit();
    test_miss();
    test_corner();
    test_end_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
